acc_snapshot_reader: RTL and testbench
======================================

// Module: acc_snapshot_reader
// PURPOSE
//   Read-side companion to the accumulator core. On request, captures a full ACC_WIDTH-bit accumulator value into a shadow register.
//   Then streams it out byte-wide, MSB byte first, over a valid/ready handshake, followed by one XOR checksum byte.
//   Sits in the top-level between the accumulator's data bus and the dedicated output pins.
//   This exposes the whole accumulator value instead of only its MSB.
// PARAMETERS
//   ACC_WIDTH  64  accumulator width in bits; must be a multiple of 8 and >= 16
//   NBYTES     ACC_WIDTH/8  localparam, number of data bytes per frame
// PORTS
//   clk        in   1          single clock; all state on rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   acc_data   in   ACC_WIDTH  live accumulator value
//   snap_req   in   1          request a snapshot (level; sampled only in IDLE)
//   out_data   out  8          current output byte
//   out_valid  out  1          out_data is valid
//   out_ready  in   1          consumer accepts byte when out_valid & out_ready
//   out_last   out  1          high with the checksum byte (final beat of frame)
//   busy       out  1          high whenever state != IDLE
//   overrun    out  1          sticky: snap_req seen while busy
// BEHAVIOUR
//   Reset (async assert, clk-synchronous release): state=IDLE, shadow=0, byte_cnt=0, csum=0.
//     All outputs drive 0 while reset is asserted.
//   States: IDLE -> SEND -> CSUM -> IDLE.
//   IDLE: out_valid=0, busy=0. If snap_req=1 at edge N: shadow<=acc_data, byte_cnt<=0, csum<=0, overrun<=0, state<=SEND.
//     out_valid is high in cycle N+1 (1-cycle latency from request to first beat).
//   SEND: out_data=shadow byte [ACC_WIDTH-1-8*byte_cnt -: 8]; out_valid=1; out_last=0.
//     On beat (valid&ready): csum<=csum^out_data, byte_cnt++.
//     On the beat with byte_cnt==NBYTES-1: state<=CSUM.
//     No beat: out_data and out_valid are held stable (no retraction, no change).
//   CSUM: out_data=csum, out_valid=1, out_last=1. On beat: state<=IDLE, byte_cnt<=0.
//   Frame = NBYTES+1 beats. Minimum frame period = NBYTES+2 cycles (one IDLE cycle between frames).
//     No back-to-back frame start.
//   acc_data changes after capture do not affect the frame in flight.
//   snap_req while busy: ignored (no queuing); overrun<=1 and stays set until the next accepted request clears it.
//   snap_req held high continuously: a new frame starts on the first IDLE cycle after each frame.
//   out_ready may be high while out_valid=0; this has no effect.
//   Reset asserted mid-frame: frame is abandoned immediately; no partial beat is completed.
//   byte_cnt width = $clog2(NBYTES); it never wraps past NBYTES-1.
// STRUCTURE
//   Shared package tt_acc_pkg: state enum {IDLE,SEND,CSUM}, localparam BYTE_W=8, ACC_WIDTH default 64.
//   Same package is used by the accumulator and the top level.
//   Single flat module: shadow register, byte counter, checksum register, 3-state FSM.
//     Byte select is an indexed part-select; no sub-module is warranted.
//   Top-level wiring: uo_out=out_data; out_ready/snap_req on uio_in bits; out_valid/out_last on uio_out with matching uio_oe.
// TESTING
//   1. Reset: rst_n=0 mid-cycle -> out_valid=0, busy=0, overrun=0, out_data=0 immediately (async).
//   2. acc_data=0x0123456789ABCDEF, pulse snap_req, out_ready=1 -> beats 01,23,45,67,89,AB,CD,EF then 00 with out_last=1.
//      busy falls after 9 beats; first out_valid exactly 1 cycle after the request edge.
//   3. acc_data=0x8000000000000001, out_ready toggling randomly -> bytes 80,00x6,01, checksum 81.
//      out_data stays stable across every stall cycle.
//      Change acc_data during the frame -> output unaffected.
//   4. snap_req pulsed during beat 3 -> frame unchanged, overrun=1.
//      Next accepted snap_req clears overrun in the following cycle.
//   5. Assert rst_n=0 after 4 beats -> all outputs 0; after release and a new snap_req, a full 9-beat frame from byte 0.
//   6. snap_req held high, out_ready=1 -> consecutive frames with exactly one idle (out_valid=0) cycle between them.

Source files
------------

// File: rtl/tt_acc_pkg.sv
// Shared definitions for the accumulator core and its read-side companions.
package tt_acc_pkg;

    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned ACC_WIDTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

endpackage

// File: rtl/acc_snapshot_reader.sv
// Captures the accumulator into a shadow register and streams it MSB byte first over
// valid/ready, followed by one XOR checksum byte flagged with out_last.
module acc_snapshot_reader
    import tt_acc_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ACC_WIDTH-1:0] acc_data,
    input  logic                 snap_req,
    output logic [BYTE_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned NBYTES = ACC_WIDTH / BYTE_W;
    localparam int unsigned CNT_W  = $clog2(NBYTES);
    localparam int unsigned IDX_W  = $clog2(ACC_WIDTH);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BYTE_W-1:0]      csum_q, csum_d;
    logic                   overrun_q, overrun_d;
    logic [IDX_W-1:0]       msb_idx;
    logic                   beat;

    assign msb_idx = IDX_W'(ACC_WIDTH - 1 - BYTE_W * cnt_q);
    assign beat    = out_valid & out_ready;

    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            SEND: begin
                out_data  = shadow_q[msb_idx -: BYTE_W];
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            CSUM: begin
                out_data  = csum_q;
                out_valid = 1'b1;
                out_last  = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign overrun = overrun_q;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        overrun_d = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (snap_req) begin
                    shadow_d  = acc_data;
                    cnt_d     = '0;
                    csum_d    = '0;
                    overrun_d = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (snap_req) overrun_d = 1'b1;
                if (beat) begin
                    csum_d = csum_q ^ out_data;
                    // Counter parks on the last index rather than wrapping.
                    if (cnt_q == LAST_CNT) begin
                        state_d = CSUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CSUM: begin
                if (snap_req) overrun_d = 1'b1;
                if (beat) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_acc_snapshot_reader.sv
// Scoreboard bench for acc_snapshot_reader: stimulus queues expected beats, a monitor checks them.
module tb_acc_snapshot_reader;

    logic        clk;
    logic        rst_n;
    logic [63:0] acc_data;
    logic        snap_req;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int beats  = 0;

    logic [8:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    acc_snapshot_reader #(.ACC_WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_data  (acc_data),
        .snap_req  (snap_req),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Expected beats for one frame: 8 data bytes MSB first, then the XOR checksum.
    task automatic push_frame(input logic [63:0] v);
        logic [7:0] b;
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b  = 8'(v >> (56 - 8 * i));
            cs = cs ^ b;
            exp_q.push_back({1'b0, b});
        end
        exp_q.push_back({1'b1, cs});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target, input int budget, input bit rnd);
        int n;
        n = 0;
        while (beats < target && n < budget) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("beat_timeout", 32'(beats >= target), 32'd1);
    endtask

    // Monitor: handshake is decided by values stable before the next rising edge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e[7:0]));
                    check("beat_last", 32'(out_last), 32'(e[8]));
                end
                beats++;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n     = 1'b1;
        acc_data  = 64'h0;
        snap_req  = 1'b0;
        out_ready = 1'b0;

        // 1. Asynchronous reset, asserted between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();

        // 2. Basic frame, consumer always ready.
        base      = beats;
        out_ready = 1'b1;
        acc_data  = 64'h0123456789ABCDEF;
        check("idle_valid", 32'(out_valid), 32'd0);
        snap_req = 1'b1;
        push_frame(acc_data);
        tick();
        snap_req = 1'b0;
        check("first_valid_latency", 32'(out_valid), 32'd1);
        check("busy_in_frame", 32'(busy), 32'd1);
        wait_beats(base + 8, 20, 1'b0);
        check("busy_before_csum", 32'(busy), 32'd1);
        wait_beats(base + 9, 5, 1'b0);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("valid_after_frame", 32'(out_valid), 32'd0);

        // 3. Random back-pressure; capture must isolate the frame from acc_data.
        tick();
        base      = beats;
        acc_data  = 64'h8000000000000001;
        snap_req  = 1'b1;
        push_frame(acc_data);
        tick();
        snap_req = 1'b0;
        wait_beats(base + 2, 200, 1'b1);
        acc_data = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_beats(base + 9, 400, 1'b1);
        out_ready = 1'b1;
        check("busy_after_stalled_frame", 32'(busy), 32'd0);

        // 4. Request during a frame is dropped and flagged.
        tick();
        base     = beats;
        acc_data = 64'h1122334455667788;
        snap_req = 1'b1;
        push_frame(acc_data);
        tick();
        snap_req = 1'b0;
        wait_beats(base + 3, 20, 1'b0);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        wait_beats(base + 9, 20, 1'b0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("idle_after_overrun", 32'(busy), 32'd0);
        acc_data = 64'hDEADBEEFCAFEF00D;
        snap_req = 1'b1;
        push_frame(acc_data);
        tick();
        snap_req = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);
        wait_beats(base + 18, 20, 1'b0);

        // 5. Reset mid-frame abandons it; next frame restarts from byte 0.
        tick();
        base     = beats;
        acc_data = 64'hA5A5_5A5A_0F0F_F0F0;
        snap_req = 1'b1;
        push_frame(acc_data);
        tick();
        snap_req = 1'b0;
        wait_beats(base + 4, 20, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_last", 32'(out_last), 32'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        tick();
        base     = beats;
        acc_data = 64'h0011223344556677;
        snap_req = 1'b1;
        push_frame(acc_data);
        tick();
        snap_req = 1'b0;
        wait_beats(base + 9, 20, 1'b0);

        // 6. Held request: frames repeat with exactly one idle cycle between them.
        tick();
        base     = beats;
        acc_data = 64'h0F1E2D3C4B5A6978;
        push_frame(acc_data);
        push_frame(acc_data);
        snap_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("held_valid_pattern", 32'(out_valid), 32'((k % 10) != 0));
            if (k == 11) snap_req = 1'b0;
        end
        tick();
        check("held_beat_count", 32'(beats - base), 32'd18);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
